// File: rtl/carry_4bit_lookahead_pkg.sv
// Shared constants and types for the 4-bit carry-lookahead adder.
package carry_4bit_lookahead_pkg;
   localparam int CLA_W = 4;
   typedef logic [CLA_W-1:0] nibble_t;
endpackage

// File: rtl/carry_4bit_lookahead_cla_logic.sv
// Combinational 4-bit lookahead core: flat two-level carries, no ripple chain.
// Zero latency; no flow control.
module cla_logic_4bit
   import carry_4bit_lookahead_pkg::*;
(
   input  nibble_t A,
   input  nibble_t B,
   input  logic    cin,
   output nibble_t sum,
   output logic    c4,
   output logic    gp,
   output logic    gg
);
   nibble_t g;
   nibble_t p;
   logic    c1, c2, c3;

   assign g = A & B;
   assign p = A ^ B;

   // Every carry is expanded directly from g/p and cin so no carry waits on another.
   assign c1 = g[0] | (p[0] & cin);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);

   assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign gp  = &p;
   assign sum = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/carry_4bit_lookahead.sv
// 4-bit carry-lookahead adder with registered sum, carry out and group gp/gg.
// One-cycle latency, one result per cycle; no handshake, cannot stall.
module carry_4bit_lookahead
   import carry_4bit_lookahead_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       gp,
   output logic       gg
);
   nibble_t sum_next;
   logic    c4_next;
   logic    gp_next;
   logic    gg_next;

   cla_logic_4bit u_cla (
      .A   (A),
      .B   (B),
      .cin (cin),
      .sum (sum_next),
      .c4  (c4_next),
      .gp  (gp_next),
      .gg  (gg_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s    <= '0;
         cout <= 1'b0;
         gp   <= 1'b0;
         gg   <= 1'b0;
      end else begin
         s    <= sum_next;
         cout <= c4_next;
         gp   <= gp_next;
         gg   <= gg_next;
      end
   end
endmodule

// File: tb/tb_carry_4bit_lookahead.sv
// Self-checking bench: directed cases, exhaustive sweep, random traffic and mid-stream reset.
module tb_carry_4bit_lookahead;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       cin;
   logic [3:0] s;
   logic       cout;
   logic       gp;
   logic       gg;

   int total = 0;
   int bad   = 0;

   carry_4bit_lookahead dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .cin   (cin),
      .s     (s),
      .cout  (cout),
      .gp    (gp),
      .gg    (gg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer addition; gp means every bit propagates, gg means A+B alone overflows.
   task automatic step(input string tag, input int a, input int b, input int c);
      int total_sum;
      A   = 4'(a);
      B   = 4'(b);
      cin = c[0];
      @(posedge clk);
      #1;
      total_sum = a + b + c;
      chk({tag, ".sum5"}, {3'b0, cout, s}, 8'(total_sum));
      chk({tag, ".gp"}, {7'b0, gp}, {7'b0, ((a ^ b) & 15) == 15});
      chk({tag, ".gg"}, {7'b0, gg}, {7'b0, (a + b) > 15});
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {cout, gp, gg, 1'b0, s}, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      A = 4'd9; B = 4'd7; cin = 1'b0;
      #2;
      chk_zero("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_zero("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      step("d_8_5_0",   8,  5, 0);
      step("d_9_7_0",   9,  7, 0);
      step("d_4_5_1",   4,  5, 1);
      step("d_8_3_1",   8,  3, 1);
      step("d_13_5_1", 13,  5, 1);
      step("d_max",    15, 15, 1);
      step("d_zero",    0,  0, 0);
      step("d_prop",   10,  5, 1);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               step("sweep", a, b, c);

      for (int i = 0; i < 200; i++)
         step("rand", int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));

      // Assert reset between edges while holding a non-zero result.
      step("pre_rst", 15, 15, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("reset_mid");
      @(posedge clk);
      #1;
      chk_zero("reset_mid_hold");
      A = 4'd6; B = 4'd11; cin = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 6, 11, 1);
      step("post_rst2", 3, 12, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
